// File: rtl/rpc2_ctrl_cfg_sync_axiclk.sv
// rpc2_ctrl_cfg_sync_axiclk: multi-channel config-field synchronizer with stability filter into the AXI clock domain
// Ports: AXIm_ACLK/AXIm_ARESETN clock and async active-low reset; cfg_in source fields (channel c at [c*WIDTH +: WIDTH]);
// cfg_hold freezes output updates; cfg_out filtered fields; cfg_chg per-channel update pulse; cfg_settled no change pending.
module rpc2_ctrl_cfg_sync_axiclk #(
  parameter int NUM_CH = 2,
  parameter int WIDTH = 2,
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CYCLES = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                    AXIm_ACLK,
  input  logic                    AXIm_ARESETN,
  input  logic [NUM_CH*WIDTH-1:0] cfg_in,
  input  logic                    cfg_hold,
  output logic [NUM_CH*WIDTH-1:0] cfg_out,
  output logic [NUM_CH-1:0]       cfg_chg,
  output logic [NUM_CH-1:0]       cfg_settled
);
  localparam int N = NUM_CH * WIDTH;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES - 1);
  logic [SYNC_STAGES-1:0][N-1:0] sync_q, sync_d;
  logic [N-1:0] cand_q, cand_d, out_q, out_d;
  logic [NUM_CH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0] chg_q, chg_d;
  logic [WIDTH-1:0] sl, cd, od;
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], cfg_in};
    cand_d = cand_q;
    out_d = out_q;
    cnt_d = cnt_q;
    chg_d = '0;
    cfg_settled = '0;
    sl = '0;
    cd = '0;
    od = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sl = sync_q[SYNC_STAGES-1][c*WIDTH +: WIDTH];
      cd = cand_q[c*WIDTH +: WIDTH];
      od = out_q[c*WIDTH +: WIDTH];
      cfg_settled[c] = (sl == cd) && (cd == od);
      if (sl != cd) begin
        cand_d[c*WIDTH +: WIDTH] = sl;
        cnt_d[c] = '0;
      end else if (cd != od && cnt_q[c] == CMAX && !cfg_hold) begin
        out_d[c*WIDTH +: WIDTH] = cd;
        chg_d[c] = 1'b1;
        cnt_d[c] = '0;
      end else if (cd != od) begin
        // saturate so a held, fully qualified value fires on the first unheld edge
        cnt_d[c] = (cnt_q[c] == CMAX) ? CMAX : cnt_q[c] + 1'b1;
      end else begin
        cnt_d[c] = '0;
      end
    end
  end
  always_ff @(posedge AXIm_ACLK or negedge AXIm_ARESETN) begin
    if (!AXIm_ARESETN) begin
      sync_q <= {(SYNC_STAGES*NUM_CH){RESET_VAL}};
      cand_q <= {NUM_CH{RESET_VAL}};
      out_q <= {NUM_CH{RESET_VAL}};
      cnt_q <= '0;
      chg_q <= '0;
    end else begin
      sync_q <= sync_d;
      cand_q <= cand_d;
      out_q <= out_d;
      cnt_q <= cnt_d;
      chg_q <= chg_d;
    end
  end
  assign cfg_out = out_q;
  assign cfg_chg = chg_q;
endmodule

// File: tb/tb_rpc2_ctrl_cfg_sync_axiclk.sv
// tb_rpc2_ctrl_cfg_sync_axiclk: three configurations checked against a sliding-window stability model
module tb_rpc2_ctrl_cfg_sync_axiclk;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hold = 1'b0;
  logic [3:0] cin0 = '0, cin1 = '0;
  logic [11:0] cin2 = '0;
  logic [3:0] o0, o1;
  logic [11:0] o2;
  logic [1:0] chg0, chg1, set0, set1;
  logic [3:0] chg2, set2;
  int nvec = 0;
  int nerr = 0;
  always #5 clk = ~clk;

  rpc2_ctrl_cfg_sync_axiclk u0 (
    .AXIm_ACLK(clk), .AXIm_ARESETN(rst_n), .cfg_in(cin0), .cfg_hold(hold),
    .cfg_out(o0), .cfg_chg(chg0), .cfg_settled(set0));
  rpc2_ctrl_cfg_sync_axiclk #(.NUM_CH(2), .WIDTH(2), .SYNC_STAGES(2), .STABLE_CYCLES(3)) u1 (
    .AXIm_ACLK(clk), .AXIm_ARESETN(rst_n), .cfg_in(cin1), .cfg_hold(hold),
    .cfg_out(o1), .cfg_chg(chg1), .cfg_settled(set1));
  rpc2_ctrl_cfg_sync_axiclk #(.NUM_CH(4), .WIDTH(3), .SYNC_STAGES(3), .STABLE_CYCLES(1)) u2 (
    .AXIm_ACLK(clk), .AXIm_ARESETN(rst_n), .cfg_in(cin2), .cfg_hold(hold),
    .cfg_out(o2), .cfg_chg(chg2), .cfg_settled(set2));

  function automatic int nch(int i); return i == 2 ? 4 : 2; endfunction
  function automatic int wd(int i); return i == 2 ? 3 : 2; endfunction
  function automatic int ss(int i); return i == 2 ? 3 : 2; endfunction
  function automatic int st(int i); return i == 0 ? 2 : (i == 1 ? 3 : 1); endfunction
  function automatic logic [11:0] fld(logic [11:0] x, int c, int w);
    return (x >> (c * w)) & ((12'd1 << w) - 12'd1);
  endfunction

  logic [11:0] ci [3], ao [3];
  logic [3:0] ac [3], as_ [3];
  always_comb begin
    ci[0] = {8'b0, cin0}; ci[1] = {8'b0, cin1}; ci[2] = cin2;
    ao[0] = {8'b0, o0}; ao[1] = {8'b0, o1}; ao[2] = o2;
    ac[0] = {2'b0, chg0}; ac[1] = {2'b0, chg1}; ac[2] = chg2;
    as_[0] = {2'b0, set0}; as_[1] = {2'b0, set1}; as_[2] = set2;
  end

  // Model: a value is adopted once the synchronized field has shown the same
  // value for STABLE_CYCLES+1 consecutive samples and hold is low.
  logic [11:0] pipe [3][4], hist [3][4], eo [3];
  logic [3:0] ec [3], es [3];
  logic [11:0] m_sl, m_v, m_mask;
  bit m_ok;
  initial forever begin
    @(posedge clk or negedge rst_n);
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        for (int k = 0; k < 4; k++) begin pipe[i][k] = '0; hist[i][k] = '0; end
        eo[i] = '0;
        ec[i] = '0;
      end else begin
        m_sl = pipe[i][ss(i)-1];
        for (int k = 3; k > 0; k--) hist[i][k] = hist[i][k-1];
        hist[i][0] = m_sl;
        ec[i] = '0;
        for (int c = 0; c < nch(i); c++) begin
          m_v = fld(m_sl, c, wd(i));
          m_ok = 1'b1;
          for (int k = 1; k <= st(i); k++) if (fld(hist[i][k], c, wd(i)) != m_v) m_ok = 1'b0;
          if (m_ok && m_v != fld(eo[i], c, wd(i)) && !hold) begin
            m_mask = ((12'd1 << wd(i)) - 12'd1) << (c * wd(i));
            eo[i] = (eo[i] & ~m_mask) | (m_v << (c * wd(i)));
            ec[i][c] = 1'b1;
          end
        end
        for (int k = 3; k > 0; k--) pipe[i][k] = pipe[i][k-1];
        pipe[i][0] = ci[i];
      end
      es[i] = '0;
      for (int c = 0; c < nch(i); c++)
        es[i][c] = fld(pipe[i][ss(i)-1], c, wd(i)) == fld(hist[i][0], c, wd(i)) &&
                   fld(hist[i][0], c, wd(i)) == fld(eo[i], c, wd(i));
    end
  end

  task test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    nvec++;
    if (o0 !== 4'h0 || chg0 !== 2'b00 || set0 !== 2'b11) begin
      nerr++; $display("FAIL reset_u0 out=%h chg=%b settled=%b want 0 00 11", o0, chg0, set0);
    end
    nvec++;
    if (o1 !== 4'h0 || chg1 !== 2'b00 || set1 !== 2'b11) begin
      nerr++; $display("FAIL reset_u1 out=%h chg=%b settled=%b want 0 00 11", o1, chg1, set1);
    end
    nvec++;
    if (o2 !== 12'h0 || chg2 !== 4'b0000 || set2 !== 4'b1111) begin
      nerr++; $display("FAIL reset_u2 out=%h chg=%b settled=%b want 0 0000 1111", o2, chg2, set2);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    nvec++;
    if (o0 !== 4'h0 || chg0 !== 2'b00 || set0 !== 2'b11) begin
      nerr++; $display("FAIL after_reset_u0 out=%h chg=%b settled=%b want 0 00 11", o0, chg0, set0);
    end
  endtask

  task test_latency;
    cin0[1:0] = 2'b10;
    for (int e = 1; e <= 7; e++) begin
      @(negedge clk);
      nvec++;
      if (o0 !== (e >= 5 ? 4'b0010 : 4'b0000) || chg0 !== (e == 5 ? 2'b01 : 2'b00)) begin
        nerr++; $display("FAIL latency edge=%0d out=%h chg=%b want out=%h chg=%b", e, o0, chg0,
                         e >= 5 ? 4'b0010 : 4'b0000, e == 5 ? 2'b01 : 2'b00);
      end
    end
  endtask

  task test_glitch;
    cin1[3:2] = 2'b11;
    @(negedge clk);
    cin1[3:2] = 2'b00;
    for (int e = 0; e < 12; e++) begin
      @(negedge clk);
      nvec++;
      if (o1 !== 4'h0 || chg1 !== 2'b00) begin
        nerr++; $display("FAIL glitch cyc=%0d out=%h chg=%b want 0 00", e, o1, chg1);
      end
    end
    nvec++;
    if (set1 !== 2'b11) begin
      nerr++; $display("FAIL glitch_settled settled=%b want 11", set1);
    end
  endtask

  task test_skew;
    int pulses;
    cin0[1:0] = 2'b00;
    repeat (8) @(negedge clk);
    cin0[1:0] = 2'b01;
    @(negedge clk);
    cin0[1:0] = 2'b11;
    pulses = 0;
    for (int e = 0; e < 10; e++) begin
      @(negedge clk);
      pulses += int'(chg0[0]);
      nvec++;
      if (o0[1:0] === 2'b01) begin
        nerr++; $display("FAIL skew_torn cyc=%0d out=%b want never 01", e, o0[1:0]);
      end
    end
    nvec++;
    if (o0 !== 4'b0011 || pulses != 1) begin
      nerr++; $display("FAIL skew_final out=%h pulses=%0d want 3 1", o0, pulses);
    end
  endtask

  task test_hold;
    cin0[1:0] = 2'b00;
    repeat (8) @(negedge clk);
    hold = 1'b1;
    cin0[1:0] = 2'b01;
    for (int e = 0; e < 10; e++) begin
      @(negedge clk);
      nvec++;
      if (o0 !== 4'h0 || chg0 !== 2'b00) begin
        nerr++; $display("FAIL hold cyc=%0d out=%h chg=%b want 0 00", e, o0, chg0);
      end
    end
    nvec++;
    if (set0[0] !== 1'b0) begin
      nerr++; $display("FAIL hold_settled settled0=%b want 0", set0[0]);
    end
    hold = 1'b0;
    @(negedge clk);
    nvec++;
    if (o0 !== 4'b0001 || chg0 !== 2'b01) begin
      nerr++; $display("FAIL hold_release out=%h chg=%b want 1 01", o0, chg0);
    end
    @(negedge clk);
    nvec++;
    if (chg0 !== 2'b00 || set0 !== 2'b11) begin
      nerr++; $display("FAIL hold_after chg=%b settled=%b want 00 11", chg0, set0);
    end
  endtask

  task test_reset_mid;
    cin0[1:0] = 2'b10;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    nvec++;
    if (o0 !== 4'h0 || chg0 !== 2'b00 || set0 !== 2'b11) begin
      nerr++; $display("FAIL reset_mid out=%h chg=%b settled=%b want 0 00 11", o0, chg0, set0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(negedge clk);
      nvec++;
      if (o0 !== (e >= 5 ? 4'b0010 : 4'b0000) || chg0 !== (e == 5 ? 2'b01 : 2'b00)) begin
        nerr++; $display("FAIL reset_mid_relat edge=%0d out=%h chg=%b want out=%h chg=%b", e, o0, chg0,
                         e >= 5 ? 4'b0010 : 4'b0000, e == 5 ? 2'b01 : 2'b00);
      end
    end
  endtask

  task test_sweep;
    cin2 = 12'b110_000_000_101;
    for (int e = 1; e <= 7; e++) begin
      @(negedge clk);
      nvec++;
      if (o2 !== (e >= 5 ? 12'hC05 : 12'h000) || chg2 !== (e == 5 ? 4'b1001 : 4'b0000)) begin
        nerr++; $display("FAIL sweep edge=%0d out=%h chg=%b want out=%h chg=%b", e, o2, chg2,
                         e >= 5 ? 12'hC05 : 12'h000, e == 5 ? 4'b1001 : 4'b0000);
      end
    end
  endtask

  task test_random;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        nvec++;
        if (ao[i] !== eo[i] || ac[i] !== ec[i] || as_[i] !== es[i]) begin
          nerr++; $display("FAIL random u%0d cyc=%0d out=%h chg=%b settled=%b want %h %b %b",
                           i, n, ao[i], ac[i], as_[i], eo[i], ec[i], es[i]);
        end
      end
      if ($urandom_range(3) == 0) cin0 = 4'($urandom);
      if ($urandom_range(4) == 0) cin1 = 4'($urandom);
      if ($urandom_range(2) == 0) cin2 = 12'($urandom);
      hold = ($urandom_range(7) == 0);
    end
    hold = 1'b0;
  endtask

  initial begin
    test_reset;
    test_latency;
    test_glitch;
    test_skew;
    test_hold;
    test_reset_mid;
    test_sweep;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/rpc2_ctrl_cfg_sync_axiclk.md
Name: rpc2_ctrl_cfg_sync_axiclk

Overview:
- Parametrised multi-channel synchronizer that carries quasi-static controller register fields (for example, read/write transaction-allocation fields) into the AXI master clock domain.
- Each channel has a configurable N-flop synchronizer chain, followed by a stability filter and a change-strobe generator.
- An output only updates after its synchronized value has held steady for a programmable number of cycles, so multi-bit fields never present a torn value to AXI-side logic.
- An optional hold input freezes all outputs while AXI-side logic is mid-transaction.

Parameters:
- NUM_CH, 2: number of independent channels.
- WIDTH, 2: bits per channel.
- SYNC_STAGES, 2: synchronizer flops per bit; legal range 2 to 4.
- STABLE_CYCLES, 2: consecutive cycles a synchronized value must hold before it is adopted; minimum 1.
- RESET_VAL, 0: per-channel reset value, WIDTH bits, replicated across all channels.

Ports:
- AXIm_ACLK, input, 1: AXI-domain clock.
- AXIm_ARESETN, input, 1: asynchronous active-low reset.
- cfg_in, input, NUM_CH*WIDTH: source-domain fields; channel c occupies bits [c*WIDTH +: WIDTH].
- cfg_hold, input, 1: when high, no cfg_out update occurs (AXI domain, synchronous).
- cfg_out, output, NUM_CH*WIDTH: filtered, synchronized fields; registered.
- cfg_chg, output, NUM_CH: one-cycle pulse per channel, asserted in the cycle cfg_out for that channel takes a new value.
- cfg_settled, output, NUM_CH: high when the channel has no pending change. Defined as (sync_last == cand) and (cand == cfg_out).

Behaviour:
- Reset (asynchronous, active-low): every synchronizer flop, cand and cfg_out are cleared to RESET_VAL; cnt = 0; cfg_chg = 0. cfg_settled therefore reads all-ones during and after reset. Assertion mid-operation discards any pending update immediately. Deassertion requires no special sequencing.
- Synchronizer: per bit, a plain SYNC_STAGES-deep shift register with no logic between flops. sync_last is the final stage.
- Per-channel filter state: cand (WIDTH bits) and cnt (width = clog2(STABLE_CYCLES+1)). Evaluated each rising edge in priority order:
  1. sync_last != cand: cand <= sync_last; cnt <= 0 (restart qualification).
  2. Else, if cand != cfg_out and cnt == STABLE_CYCLES-1 and cfg_hold == 0: cfg_out <= cand; cfg_chg <= 1; cnt <= 0.
  3. Else, if cand != cfg_out: cnt <= cnt + 1, saturating at STABLE_CYCLES-1. While saturated under hold, the update fires on the first edge with cfg_hold == 0.
  4. Else: cnt <= 0.
  - cfg_chg is 0 on every edge where rule 2 does not fire.
- Latency: a clean input change arriving before edge 1 appears on cfg_out after edge SYNC_STAGES+1+STABLE_CYCLES, with cfg_chg high for that one cycle. Defaults give edge 5.
- Glitch or bounce: any input change shorter than STABLE_CYCLES cycles at sync_last restarts qualification. If the input returns to the cfg_out value, cand realigns and no update or cfg_chg occurs.
- Multi-bit skew: bits arriving on different cycles restart the counter. Only the final coherent value is adopted; no intermediate code appears on cfg_out.
- Channel independence: channels share only the clock, reset and cfg_hold. Simultaneous updates on several channels produce simultaneous cfg_chg bits.
- cfg_hold: affects only rule 2. Synchronization and qualification continue while it is high. If the value changes again during hold, qualification restarts (rule 1) and the value that finally qualifies is the one adopted.
- No combinational path from cfg_in or cfg_hold to any output. cfg_out and cfg_chg are registered; cfg_settled is a compare of registers only.

Test Plan:
- Reset with defaults, RESET_VAL=0 -> cfg_out=0, cfg_chg=0, cfg_settled=2'b11. Drive ch0 0->2'b10 before edge 1 -> cfg_out[1:0]=2'b10 after edge 5; cfg_chg=2'b01 for exactly that cycle; ch1 remains unchanged.
- Glitch: ch1 0->2'b11 for 1 cycle then back to 0, STABLE_CYCLES=3 -> cfg_out never changes, cfg_chg never asserts, cfg_settled[1] returns to 1.
- Skew: ch0 bit0 rises one cycle before bit1 (0->2'b01->2'b11) -> cfg_out goes directly 0->2'b11, single cfg_chg pulse, 2'b01 never observed.
- Hold: cfg_hold=1, ch0 0->2'b01, hold kept for 10 cycles -> cfg_out stays 0 with cfg_settled[0]=0; hold released -> cfg_out=2'b01 on the next edge with one cfg_chg pulse.
- Reset mid-qualification: ch0 change in flight, AXIm_ARESETN asserted at edge 3 -> outputs return to RESET_VAL asynchronously, no cfg_chg. After release with cfg_in still changed -> update after the full SYNC_STAGES+1+STABLE_CYCLES latency.
- Parametrisation sweep: NUM_CH=4, WIDTH=3, SYNC_STAGES=3, STABLE_CYCLES=1 with simultaneous changes on channels 0 and 3 -> both update at edge 5 with cfg_chg=4'b1001.
